// File: rtl/rover_pkg.sv
// Shared rover ranging definitions: FSM state codes and timing defaults used by both
// the proximity initiator and the echo responder so the two ends agree on timing.
package rover_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG_MEAS = 3'd1;
    localparam logic [2:0] ST_BURST     = 3'd2;
    localparam logic [2:0] ST_ECHO      = 3'd3;
    localparam logic [2:0] ST_HOLDOFF   = 3'd4;

    // Timing in clk cycles at a 100 MHz system clock.
    localparam int DEF_CLK_HZ       = 100_000_000;
    localparam int DEF_TRIG_MIN_CYC = 1000;
    localparam int DEF_BURST_CYC    = 20000;
    localparam int DEF_CYC_PER_CM   = 5800;
    localparam int DEF_MAX_CM       = 400;
    localparam int DEF_TIMEOUT_CYC  = 3_800_000;
    localparam int DEF_HOLDOFF_CYC  = 1_000_000;
    localparam int DEF_DIST_W       = 9;

    // Bits needed for a counter that runs 0 .. n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments make meta and q a true two-stage shift register;
    // blocking ones would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// Emulated HC-SR04 far end: qualifies the trigger pulse, waits the burst delay, then
// answers with an echo whose width encodes the latched distance (or a no-object timeout).
module ultrasonic_echo_responder
    import rover_pkg::*;
#(
    parameter int TRIG_MIN_CYC = DEF_TRIG_MIN_CYC,
    parameter int BURST_CYC    = DEF_BURST_CYC,
    parameter int CYC_PER_CM   = DEF_CYC_PER_CM,
    parameter int MAX_CM       = DEF_MAX_CM,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int HOLDOFF_CYC  = DEF_HOLDOFF_CYC,
    parameter int DIST_W       = DEF_DIST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [DIST_W-1:0] distance_cm,
    output logic              echo,
    output logic              busy,
    output logic              done
);

    localparam int TRIG_W = cnt_w(TRIG_MIN_CYC + 1);
    localparam int CYC_W  = cnt_w(CYC_PER_CM);
    localparam int CNT_W  = cnt_w(max3(TIMEOUT_CYC, HOLDOFF_CYC, BURST_CYC));

    localparam logic [TRIG_W-1:0] TRIG_SAT     = TRIG_W'(TRIG_MIN_CYC);
    localparam logic [TRIG_W-1:0] TRIG_ONE     = TRIG_W'(1);
    localparam logic [CYC_W-1:0]  CYC_LAST     = CYC_W'(CYC_PER_CM - 1);
    localparam logic [CYC_W-1:0]  CYC_ONE      = CYC_W'(1);
    localparam logic [CNT_W-1:0]  BURST_LAST   = CNT_W'(BURST_CYC - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLDOFF_LAST = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [DIST_W-1:0] DIST_ONE     = DIST_W'(1);
    localparam logic [DIST_W-1:0] DIST_MAX     = DIST_W'(MAX_CM);

    logic              trig_s;
    logic              trig_d;
    logic              trig_rise;
    logic              trig_fall;
    logic [2:0]        state;
    logic [TRIG_W-1:0] trig_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [DIST_W-1:0] cm_cnt;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [DIST_W-1:0] dist_q;
    logic              no_object;
    logic              echo_last;

    sync_2ff #(.WIDTH(1)) u_trig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trigger),
        .q     (trig_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_d <= 1'b0;
        else        trig_d <= trig_s;
    end

    assign trig_rise = trig_s & ~trig_d;
    assign trig_fall = ~trig_s & trig_d;

    // dist_q is stable for the whole measurement, so these decode straight off it.
    assign no_object = (dist_q == '0) || (dist_q > DIST_MAX);
    assign echo_last = no_object ? (cnt == TIMEOUT_LAST)
                                 : ((cm_cnt == dist_q - DIST_ONE) && (cyc_cnt == CYC_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            trig_cnt <= '0;
            cnt      <= '0;
            cm_cnt   <= '0;
            cyc_cnt  <= '0;
            dist_q   <= '0;
            echo     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so it can only ever be a one-cycle pulse.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    cm_cnt  <= '0;
                    cyc_cnt <= '0;
                    // The rising-edge cycle is already the first synced-high cycle.
                    if (trig_rise) begin
                        state    <= ST_TRIG_MEAS;
                        trig_cnt <= TRIG_ONE;
                    end
                end
                ST_TRIG_MEAS: begin
                    if (trig_fall) begin
                        if (trig_cnt >= TRIG_SAT) begin
                            state  <= ST_BURST;
                            dist_q <= distance_cm;
                            busy   <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (trig_cnt != TRIG_SAT) begin
                        trig_cnt <= trig_cnt + TRIG_ONE;
                    end
                end
                ST_BURST: begin
                    if (cnt == BURST_LAST) begin
                        state   <= ST_ECHO;
                        echo    <= 1'b1;
                        cnt     <= '0;
                        cm_cnt  <= '0;
                        cyc_cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_ECHO: begin
                    if (echo_last) begin
                        state <= ST_HOLDOFF;
                        echo  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end else if (no_object) begin
                        cnt <= cnt + CNT_ONE;
                    end else if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt <= '0;
                        cm_cnt  <= cm_cnt + DIST_ONE;
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_ONE;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == HOLDOFF_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Self-checking bench for ultrasonic_echo_responder, run with scaled-down timing so that
// every scenario (timeouts and holdoff included) completes in a few thousand cycles.
module tb_ultrasonic_echo_responder;

    localparam int TRIG_MIN = 20;
    localparam int BURST    = 50;
    localparam int CPC      = 7;
    localparam int MAX_CM   = 40;
    localparam int TIMEOUT  = 400;
    localparam int HOLDOFF  = 100;
    localparam int DIST_W   = 9;
    localparam int WAIT_MAX = 4000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trigger;
    logic [DIST_W-1:0] distance_cm;
    logic              echo;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    ultrasonic_echo_responder #(
        .TRIG_MIN_CYC (TRIG_MIN),
        .BURST_CYC    (BURST),
        .CYC_PER_CM   (CPC),
        .MAX_CM       (MAX_CM),
        .TIMEOUT_CYC  (TIMEOUT),
        .HOLDOFF_CYC  (HOLDOFF),
        .DIST_W       (DIST_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trigger     (trigger),
        .distance_cm (distance_cm),
        .echo        (echo),
        .busy        (busy),
        .done        (done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log of the DUT outputs, sampled on the falling edge.
    int   echo_rises = 0, echo_rise_cyc = 0, echo_fall_cyc = 0;
    int   done_pulses = 0, done_cycles = 0, done_cyc = 0;
    int   busy_rises = 0, busy_falls = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
    logic busy_at_rise = 1'b0;
    logic echo_prev = 1'b0, done_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        if (echo === 1'b1 && echo_prev !== 1'b1) begin
            echo_rises++;
            echo_rise_cyc = cyc;
            busy_at_rise  = busy;
        end
        if (echo !== 1'b1 && echo_prev === 1'b1) echo_fall_cyc = cyc;
        if (done === 1'b1) begin
            done_cycles++;
            if (done_prev !== 1'b1) begin
                done_pulses++;
                done_cyc = cyc;
            end
        end
        if (busy === 1'b1 && busy_prev !== 1'b1) begin
            busy_rises++;
            busy_rise_cyc = cyc;
        end
        if (busy !== 1'b1 && busy_prev === 1'b1) begin
            busy_falls++;
            busy_fall_cyc = cyc;
        end
        echo_prev = echo;
        done_prev = done;
        busy_prev = busy;
    end

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int fall_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: echo width straight from the ranging rule.
    function automatic int model_width(input int d);
        if (d == 0 || d > MAX_CM) return TIMEOUT;
        return d * CPC;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input int tw);
        trigger = 1'b1;
        repeat (tw) step();
        trigger  = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic wait_echo(input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (echo === level) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic wait_busy_fall(input int bf0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (busy_falls > bf0) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic run_measurement(input string tag, input int tw, input int d);
        int r0, d0, dc0, bf0;
        bit ok;
        r0  = echo_rises;
        d0  = done_pulses;
        dc0 = done_cycles;
        bf0 = busy_falls;
        distance_cm = DIST_W'(d);
        pulse(tw);
        wait_busy_fall(bf0, ok);
        check({tag, " completes"}, 32'(ok), 1);
        check({tag, " echo count"}, echo_rises - r0, 1);
        check({tag, " busy lead"}, busy_rise_cyc - fall_cyc, 3);
        check({tag, " latency"}, echo_rise_cyc - fall_cyc, BURST + 3);
        check({tag, " width"}, echo_fall_cyc - echo_rise_cyc, model_width(d));
        check({tag, " busy at echo"}, 32'(busy_at_rise), 1);
        check({tag, " done pulses"}, done_pulses - d0, 1);
        check({tag, " done cycles"}, done_cycles - dc0, 1);
        check({tag, " done align"}, done_cyc - echo_fall_cyc, 0);
        check({tag, " holdoff"}, busy_fall_cyc - echo_fall_cyc, HOLDOFF);
        repeat (5) step();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int  r0, b0, f0, bf0;
        bit  ok;

        rst_n       = 1'b0;
        trigger     = 1'b0;
        distance_cm = '0;
        repeat (3) step();
        check("reset echo", 32'(echo), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        rst_n = 1'b1;
        repeat (3) step();

        run_measurement("nominal", TRIG_MIN, 10);

        // Runt trigger one cycle short of the minimum.
        r0 = echo_rises;
        b0 = busy_rises;
        distance_cm = DIST_W'(10);
        pulse(TRIG_MIN - 1);
        repeat (BURST + 40) step();
        check("runt echo", echo_rises - r0, 0);
        check("runt busy", busy_rises - b0, 0);
        run_measurement("after runt", TRIG_MIN, 10);

        run_measurement("dist zero", TRIG_MIN, 0);
        run_measurement("dist over", TRIG_MIN, MAX_CM + 1);
        run_measurement("dist max", TRIG_MIN, MAX_CM);

        for (int i = 0; i < 6; i++)
            run_measurement("random", int'($urandom_range(TRIG_MIN, TRIG_MIN + 40)),
                            int'($urandom_range(0, MAX_CM + 8)));

        // Retriggers in BURST, ECHO and HOLDOFF, plus a distance change mid-echo.
        r0  = echo_rises;
        b0  = busy_rises;
        bf0 = busy_falls;
        distance_cm = DIST_W'(10);
        pulse(TRIG_MIN);
        f0 = fall_cyc;
        repeat (10) step();
        pulse(TRIG_MIN + 5);
        wait_echo(1'b1, ok);
        check("ignore echo seen", 32'(ok), 1);
        repeat (5) step();
        distance_cm = DIST_W'(50);
        pulse(TRIG_MIN + 5);
        wait_echo(1'b0, ok);
        check("ignore echo ended", 32'(ok), 1);
        pulse(TRIG_MIN + 5);
        wait_busy_fall(bf0, ok);
        check("ignore completes", 32'(ok), 1);
        repeat (BURST + 40) step();
        check("ignore echo count", echo_rises - r0, 1);
        check("ignore busy count", busy_rises - b0, 1);
        check("ignore latency", echo_rise_cyc - f0, BURST + 3);
        check("ignore width", echo_fall_cyc - echo_rise_cyc, model_width(10));

        // Long trigger, then trigger held high across the holdoff exit.
        run_measurement("stuck long", 250, 10);
        r0  = echo_rises;
        b0  = busy_rises;
        bf0 = busy_falls;
        distance_cm = DIST_W'(5);
        pulse(TRIG_MIN);
        wait_echo(1'b1, ok);
        wait_echo(1'b0, ok);
        check("held echo ended", 32'(ok), 1);
        trigger = 1'b1;
        wait_busy_fall(bf0, ok);
        check("held completes", 32'(ok), 1);
        repeat (BURST + 100) step();
        check("held echo count", echo_rises - r0, 1);
        check("held busy count", busy_rises - b0, 1);
        trigger = 1'b0;
        repeat (10) step();
        check("held release echo", echo_rises - r0, 1);
        run_measurement("fresh edge", TRIG_MIN, 5);

        // Asynchronous reset in the middle of an echo.
        distance_cm = DIST_W'(10);
        pulse(TRIG_MIN);
        wait_echo(1'b1, ok);
        repeat (10) step();
        check("pre-reset echo", 32'(echo), 1);
        rst_n = 1'b0;
        #1;
        check("async reset echo", 32'(echo), 0);
        check("async reset busy", 32'(busy), 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("post reset echo", 32'(echo), 0);
        check("post reset busy", 32'(busy), 0);
        check("post reset done", 32'(done), 0);
        run_measurement("post reset", TRIG_MIN, 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
